// File: rtl/drawline_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : drawline_arbiter
// Purpose  : Round-robin arbiter that shares one drawline engine between
//            NREQ line-command requesters. Define DRAWARB_FIXED_PRIO_EN for
//            fixed lowest-index-wins priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module drawline_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_start,
  input  logic [NREQ*8-1:0] req_x0,
  input  logic [NREQ*7-1:0] req_y0,
  input  logic [NREQ*8-1:0] req_x1,
  input  logic [NREQ*7-1:0] req_y1,
  input  logic [NREQ*3-1:0] req_colour,
  output logic [NREQ-1:0]   req_done,
  output logic              dl_start,
  output logic [7:0]        dl_x0,
  output logic [6:0]        dl_y0,
  output logic [7:0]        dl_x1,
  output logic [6:0]        dl_y1,
  output logic [2:0]        dl_colour,
  input  logic              dl_done,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_grant_id, w_grant_id_nxt;
  logic [NREQ-1:0] r_req_done, w_req_done_nxt;
  logic            r_dl_start, w_dl_start_nxt;
  logic [7:0]      r_dl_x0, r_dl_x1, w_dl_x0_nxt, w_dl_x1_nxt;
  logic [6:0]      r_dl_y0, r_dl_y1, w_dl_y0_nxt, w_dl_y1_nxt;
  logic [2:0]      r_dl_colour, w_dl_colour_nxt;
  logic            r_busy, w_busy_nxt;
  logic [IDW-1:0]  w_base, w_sel, w_cand;
  logic            w_found;

`ifdef DRAWARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt;

  assign w_base = r_rr_ptr;

  // Pointer moves past the requester just served so it goes to the back of the line.
  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (r_state == ACK && !req_start[r_grant_id]) begin
      w_rr_ptr_nxt = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end
`endif

  // First active requester at or after w_base, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IDW'((int'(w_base) + k) % NREQ);
      if (!w_found && req_start[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_id_nxt  = r_grant_id;
    w_req_done_nxt  = r_req_done;
    w_dl_start_nxt  = r_dl_start;
    w_dl_x0_nxt     = r_dl_x0;
    w_dl_y0_nxt     = r_dl_y0;
    w_dl_x1_nxt     = r_dl_x1;
    w_dl_y1_nxt     = r_dl_y1;
    w_dl_colour_nxt = r_dl_colour;
    case (r_state)
      IDLE: begin
        // A done still high from the previous line must clear before a new start.
        if (w_found && !dl_done) begin
          w_state_nxt     = RUN;
          w_grant_id_nxt  = w_sel;
          w_dl_start_nxt  = 1'b1;
          w_dl_x0_nxt     = req_x0[w_sel*8 +: 8];
          w_dl_y0_nxt     = req_y0[w_sel*7 +: 7];
          w_dl_x1_nxt     = req_x1[w_sel*8 +: 8];
          w_dl_y1_nxt     = req_y1[w_sel*7 +: 7];
          w_dl_colour_nxt = req_colour[w_sel*3 +: 3];
        end
      end
      RUN: begin
        if (dl_done) begin
          w_dl_start_nxt = 1'b0;
          w_state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (!dl_done) begin
          w_req_done_nxt             = '0;
          w_req_done_nxt[r_grant_id] = 1'b1;
          w_state_nxt                = ACK;
        end
      end
      ACK: begin
        if (!req_start[r_grant_id]) begin
          w_req_done_nxt = '0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_req_done  <= '0;
      r_dl_start  <= 1'b0;
      r_dl_x0     <= '0;
      r_dl_y0     <= '0;
      r_dl_x1     <= '0;
      r_dl_y1     <= '0;
      r_dl_colour <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_req_done  <= w_req_done_nxt;
      r_dl_start  <= w_dl_start_nxt;
      r_dl_x0     <= w_dl_x0_nxt;
      r_dl_y0     <= w_dl_y0_nxt;
      r_dl_x1     <= w_dl_x1_nxt;
      r_dl_y1     <= w_dl_y1_nxt;
      r_dl_colour <= w_dl_colour_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign req_done  = r_req_done;
  assign dl_start  = r_dl_start;
  assign dl_x0     = r_dl_x0;
  assign dl_y0     = r_dl_y0;
  assign dl_x1     = r_dl_x1;
  assign dl_y1     = r_dl_y1;
  assign dl_colour = r_dl_colour;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_drawline_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_drawline_arbiter
// Purpose  : Scoreboard bench for drawline_arbiter with a behavioural
//            drawline engine and simple requester models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drawline_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_start;
  logic [NREQ*8-1:0] req_x0, req_x1;
  logic [NREQ*7-1:0] req_y0, req_y1;
  logic [NREQ*3-1:0] req_colour;
  logic [NREQ-1:0]   req_done;
  logic              dl_start;
  logic [7:0]        dl_x0, dl_x1;
  logic [6:0]        dl_y0, dl_y1;
  logic [2:0]        dl_colour;
  logic              dl_done;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  always #5 clk = ~clk;

  drawline_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_start  (req_start),
    .req_x0     (req_x0),
    .req_y0     (req_y0),
    .req_x1     (req_x1),
    .req_y1     (req_y1),
    .req_colour (req_colour),
    .req_done   (req_done),
    .dl_start   (dl_start),
    .dl_x0      (dl_x0),
    .dl_y0      (dl_y0),
    .dl_x1      (dl_x1),
    .dl_y1      (dl_y1),
    .dl_colour  (dl_colour),
    .dl_done    (dl_done),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] exp_cmd;
  int          last_grant = 0;
  int          grant_cnt = 0;
  int          done_cnt[NREQ];
  logic        prev_dl_start = 1'b0;
  logic        prev_busy = 1'b0;
  logic [NREQ-1:0] persist = '0;
  logic        force_done = 1'b0;
  int          dl_lat = 2;
  int          lat_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {grant, x0, y0, x1, y1, colour} in bits [35:0]
  function automatic logic [63:0] pack_cmd(input int g, input int x0, input int y0,
                                           input int x1, input int y1, input int col);
    return {28'd0, 3'(g), 8'(x0), 7'(y0), 8'(x1), 7'(y1), 3'(col)};
  endfunction

  task automatic set_cmd(input int i, input int x0, input int y0,
                         input int x1, input int y1, input int col);
    req_x0[i*8 +: 8]     = 8'(x0);
    req_y0[i*7 +: 7]     = 7'(y0);
    req_x1[i*8 +: 8]     = 8'(x1);
    req_y1[i*7 +: 7]     = 7'(y1);
    req_colour[i*3 +: 3] = 3'(col);
  endtask

  task automatic monitor();
    if (dl_start && !prev_dl_start) begin
      check_eq("idle_gap", 64'(prev_busy), 64'd0);
      check_eq("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp_cmd = sb_q.pop_front();
        check_eq("grant_cmd", pack_cmd(int'(grant_id), int'(dl_x0), int'(dl_y0),
                                       int'(dl_x1), int'(dl_y1), int'(dl_colour)), exp_cmd);
        last_grant = int'(exp_cmd[35:33]);
      end
      grant_cnt++;
    end
    if (req_done != '0) begin
      check_eq("req_done_onehot", 64'(req_done), 64'(1) << last_grant);
      for (int i = 0; i < NREQ; i++) if (req_done[i]) done_cnt[i]++;
    end
    prev_dl_start = dl_start;
    prev_busy     = busy;
  endtask

  // Drawline engine and requesters, updated once per cycle away from the edge.
  task automatic models();
    if (rst) begin
      dl_done = 1'b0;
      lat_cnt = 0;
      return;
    end
    if (force_done) dl_done = 1'b1;
    else if (dl_start && !dl_done) begin
      if (lat_cnt >= dl_lat) begin
        dl_done = 1'b1;
        lat_cnt = 0;
      end else lat_cnt++;
    end else if (!dl_start && dl_done) dl_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_done[i] && req_start[i]) req_start[i] = 1'b0;
      else if (!req_done[i] && !req_start[i] && persist[i]) req_start[i] = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    models();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    check_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!dl_start && n < 50) begin step(); n++; end
    check_eq({tag, "_start"}, 64'(dl_start), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({dl_start, dl_x0, dl_y0, dl_x1, dl_y1, dl_colour, req_done, grant_id, busy});
  endfunction

  initial begin
    int n;
    int g0;
    rst = 1'b1;
    req_start = '0;
    req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0; req_colour = '0;
    dl_done = 1'b0;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    step();
    step();
    check_eq("reset_outs", outs_vec(), 64'd0);
    rst = 1'b0;

    // 1: single request on 0
    set_cmd(0, 59, 20, 50, 25, 2);
    sb_q.push_back(pack_cmd(0, 59, 20, 50, 25, 2));
    req_start[0] = 1'b1;
    step();
    check_eq("t1_latency", 64'(dl_start), 64'd1);
    n = 0;
    while (!req_done[0] && n < 100) begin step(); n++; end
    check_eq("t1_req_done", 64'(req_done), 64'd1);
    wait_idle("t1");

    // 2: all four persistent from reset
    for (int i = 0; i < NREQ; i++) set_cmd(i, 20 + i, 5 + i, 100 + i, 60 + i, i + 1);
    persist = '1;
    req_start = '1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
`ifdef DRAWARB_FIXED_PRIO_EN
      sb_q.push_back(pack_cmd(0, 20, 5, 100, 60, 1));
`else
      sb_q.push_back(pack_cmd(k % NREQ, 20 + k % NREQ, 5 + k % NREQ,
                              100 + k % NREQ, 60 + k % NREQ, k % NREQ + 1));
`endif
    end
    g0 = grant_cnt;
    n = 0;
    while (grant_cnt - g0 < 5 && n < 400) begin step(); n++; end
    check_eq("t2_grants", 64'(grant_cnt - g0), 64'd5);
    persist = '0;
    req_start = '0;
    wait_idle("t2");

    // 3: command change during RUN is ignored
    dl_lat = 6;
    set_cmd(1, 50, 10, 120, 40, 5);
    sb_q.push_back(pack_cmd(1, 50, 10, 120, 40, 5));
    req_start[1] = 1'b1;
    wait_start("t3a");
    step();
    req_x0[15:8] = 8'd10;
    step();
    step();
    check_eq("t3_x0_hold", 64'(dl_x0), 64'd50);
    wait_idle("t3a");
    check_eq("t3_x0_after", 64'(dl_x0), 64'd50);
    sb_q.push_back(pack_cmd(1, 10, 10, 120, 40, 5));
    req_start[1] = 1'b1;
    wait_start("t3b");
    check_eq("t3_x0_new", 64'(dl_x0), 64'd10);
    wait_idle("t3b");

    // 4: requester 2 abandons mid-line
    dl_lat = 3;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    set_cmd(2, 7, 8, 9, 10, 3);
    sb_q.push_back(pack_cmd(2, 7, 8, 9, 10, 3));
    req_start[2] = 1'b1;
    wait_start("t4");
    step();
    req_start[2] = 1'b0;
    wait_idle("t4");
    step();
    check_eq("t4_done_pulse", 64'(done_cnt[2]), 64'd1);
    check_eq("t4_idle_start", 64'(dl_start), 64'd0);

    // 5: reset during RUN, then round-robin restarts at 0
    set_cmd(0, 1, 2, 3, 4, 5);
    sb_q.push_back(pack_cmd(0, 1, 2, 3, 4, 5));
    req_start[0] = 1'b1;
    wait_start("t5");
    step();
    rst = 1'b1;
    req_start = '0;
    step();
    check_eq("t5_rst_outs", outs_vec(), 64'd0);
    rst = 1'b0;
    set_cmd(1, 11, 12, 13, 14, 6);
    set_cmd(3, 31, 32, 33, 34, 7);
    sb_q.push_back(pack_cmd(1, 11, 12, 13, 14, 6));
    sb_q.push_back(pack_cmd(3, 31, 32, 33, 34, 7));
    req_start[1] = 1'b1;
    req_start[3] = 1'b1;
    g0 = grant_cnt;
    n = 0;
    while ((grant_cnt - g0 < 2 || busy) && n < 200) begin step(); n++; end
    check_eq("t5_grants", 64'(grant_cnt - g0), 64'd2);
    check_eq("t5_idle", 64'(busy), 64'd0);

    // 6: stale dl_done blocks a grant
    dl_done = 1'b1;
    force_done = 1'b1;
    set_cmd(0, 60, 30, 70, 35, 4);
    sb_q.push_back(pack_cmd(0, 60, 30, 70, 35, 4));
    req_start[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t6_no_start", 64'(dl_start), 64'd0);
      check_eq("t6_no_busy", 64'(busy), 64'd0);
    end
    force_done = 1'b0;
    dl_done = 1'b0;
    step();
    check_eq("t6_grant", 64'(dl_start), 64'd1);
    wait_idle("t6");

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
